// File: rtl/lpc_synthesis_filter.sv
// ---------------------------------------------------------------------------
// lpc_synthesis_filter
//   All-pole synthesis filter. It rebuilds a sample stream from a prediction-error
//   stream, which undoes the FIR/LMS canceller at the transmit end:
//     d[n] = sat(e[n] + h1*d[n-1] + h2*d[n-2] + h3*d[n-3])
//   All data is signed Q(NB_DATA/2).(NB_DATA/2).
//   A three-state FSM (IDLE -> MUL -> ACC) accepts one sample every 3 cycles.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_clear      flush history d[n-1..n-3]; coefficients are kept
//   i_coef_we    coefficient write strobe
//   i_coef_addr  1..3 selects h1..h3; 0 is ignored
//   i_coef_data  coefficient value
//   i_valid      error sample valid
//   i_e          error sample e[n]
//   o_ready      block can accept a sample this cycle (IDLE only)
//   o_valid      one-cycle pulse, o_d carries a new sample
//   o_d          reconstructed sample, held until the next o_valid
// ---------------------------------------------------------------------------
module lpc_synthesis_filter #(
   parameter int NB_DATA = 32,
   parameter int N_TAPS  = 3
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_clear,
   input  logic               i_coef_we,
   input  logic [1:0]         i_coef_addr,
   input  logic [NB_DATA-1:0] i_coef_data,
   input  logic               i_valid,
   input  logic [NB_DATA-1:0] i_e,
   output logic               o_ready,
   output logic               o_valid,
   output logic [NB_DATA-1:0] o_d
);

   localparam int FRAC = NB_DATA / 2;
   localparam int NP   = 2 * NB_DATA;
   localparam int NA   = NB_DATA + 2;   // holds e plus three saturated products without overflow

   localparam logic [NB_DATA-1:0] SMAX = {1'b0, {(NB_DATA-1){1'b1}}};
   localparam logic [NB_DATA-1:0] SMIN = {1'b1, {(NB_DATA-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

   state_t                     state_q;
   logic signed [NB_DATA-1:0]  h_q    [N_TAPS];
   logic signed [NB_DATA-1:0]  hist_q [N_TAPS];   // hist_q[0] = d[n-1]
   logic signed [NP-1:0]       prod_q [N_TAPS];
   logic signed [NB_DATA-1:0]  e_q;
   logic                       clr_pend_q;
   logic                       ready_q;
   logic                       valid_q;
   logic [NB_DATA-1:0]         d_q;

   logic signed [NP-1:0]       pt;
   logic [NB_DATA-1:0]         ps;
   logic [NA-1:0]              acc;
   logic signed [NB_DATA-1:0]  d_d;

   // Each product is truncated back to Q16.16. The arithmetic shift floors
   // toward -inf. The result is saturated to NB_DATA bits and then summed
   // with e at full width. Only the final sum is saturated again.
   always_comb begin
      pt  = '0;
      ps  = '0;
      acc = {{2{e_q[NB_DATA-1]}}, e_q};
      for (int k = 0; k < N_TAPS; k++) begin
         pt = prod_q[k] >>> FRAC;
         if ((&pt[NP-1:NB_DATA-1]) || (~|pt[NP-1:NB_DATA-1]))
            ps = pt[NB_DATA-1:0];
         else
            ps = pt[NP-1] ? SMIN : SMAX;
         acc = acc + {{2{ps[NB_DATA-1]}}, ps};
      end
      if ((&acc[NA-1:NB_DATA-1]) || (~|acc[NA-1:NB_DATA-1]))
         d_d = acc[NB_DATA-1:0];
      else
         d_d = acc[NA-1] ? SMIN : SMAX;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         e_q        <= '0;
         clr_pend_q <= 1'b0;
         ready_q    <= 1'b1;
         valid_q    <= 1'b0;
         d_q        <= '0;
         for (int k = 0; k < N_TAPS; k++) begin
            h_q[k]    <= '0;
            hist_q[k] <= '0;
            prod_q[k] <= '0;
         end
      end else begin
         valid_q <= 1'b0;

         // A coefficient write in MUL lands on the same edge that registers the
         // products, so it only affects the next sample.
         for (int k = 0; k < N_TAPS; k++)
            if (i_coef_we && (i_coef_addr == 2'(k + 1)))
               h_q[k] <= i_coef_data;

         case (state_q)
            IDLE: begin
               // The clear lands before MUL reads the history, so a sample
               // accepted on the same edge sees zeroed history.
               if (i_clear)
                  for (int k = 0; k < N_TAPS; k++) hist_q[k] <= '0;
               if (i_valid) begin
                  e_q     <= i_e;
                  ready_q <= 1'b0;
                  state_q <= MUL;
               end
            end
            MUL: begin
               for (int k = 0; k < N_TAPS; k++)
                  prod_q[k] <= NP'(h_q[k]) * NP'(hist_q[k]);
               if (i_clear) clr_pend_q <= 1'b1;
               state_q <= ACC;
            end
            ACC: begin
               d_q     <= d_d;
               valid_q <= 1'b1;
               // A clear seen in MUL or ACC overrides the shift. The current
               // output still completes.
               if (clr_pend_q || i_clear) begin
                  for (int k = 0; k < N_TAPS; k++) hist_q[k] <= '0;
               end else begin
                  hist_q[0] <= d_d;
                  for (int k = 1; k < N_TAPS; k++) hist_q[k] <= hist_q[k-1];
               end
               clr_pend_q <= 1'b0;
               ready_q    <= 1'b1;
               state_q    <= IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign o_ready = ready_q;
   assign o_valid = valid_q;
   assign o_d     = d_q;

endmodule

// File: tb/tb_lpc_synthesis_filter.sv
module tb_lpc_synthesis_filter;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_clear = 1'b0;
   logic        i_coef_we = 1'b0;
   logic [1:0]  i_coef_addr = '0;
   logic [31:0] i_coef_data = '0;
   logic        i_valid = 1'b0;
   logic [31:0] i_e = '0;
   logic        o_ready;
   logic        o_valid;
   logic [31:0] o_d;

   always #5 i_clk = ~i_clk;

   lpc_synthesis_filter #(.NB_DATA(32), .N_TAPS(3)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear),
      .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data),
      .i_valid(i_valid), .i_e(i_e), .o_ready(o_ready), .o_valid(o_valid), .o_d(o_d)
   );

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          rd = 0;
   logic [31:0] obs_q[$];
   int          obs_cyc[$];
   logic [31:0] exp_q[$];

   always @(posedge i_clk) cyc <= cyc + 1;

   // Output monitor: record every produced sample and its cycle number
   always @(negedge i_clk)
      if (o_valid) begin
         obs_q.push_back(o_d);
         obs_cyc.push_back(cyc);
      end

   task automatic wr_coef(input logic [1:0] a, input logic [31:0] v);
      i_coef_we = 1'b1; i_coef_addr = a; i_coef_data = v;
      @(negedge i_clk);
      i_coef_we = 1'b0;
   endtask

   task automatic clr();
      i_clear = 1'b1;
      @(negedge i_clk);
      i_clear = 1'b0;
   endtask

   // Wait for o_ready, then transfer one sample. Returns at the negedge after
   // the accept edge, when the DUT is in MUL.
   task automatic send(input logic [31:0] e, input logic [31:0] exp_d, input bit push);
      int t = 0;
      while (!o_ready && t < 50) begin @(negedge i_clk); t++; end
      if (!o_ready) begin
         n_vec++; n_err++;
         $display("FAIL send_ready_timeout: o_ready=%0b want 1", o_ready);
      end
      i_valid = 1'b1; i_e = e;
      @(negedge i_clk);
      i_valid = 1'b0;
      if (push) exp_q.push_back(exp_d);
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      repeat (2) @(negedge i_clk);
      n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", o_valid); end
      n_vec++; if (o_d !== 32'h0) begin n_err++; $display("FAIL reset_d: got %08h want 00000000", o_d); end
      i_rst_n = 1'b1;
      @(negedge i_clk);
      n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b want 1", o_ready); end
   endtask

   task automatic test_impulse();
      int t = 0;
      wr_coef(2'd1, 32'h0000_8000); wr_coef(2'd2, 32'h0); wr_coef(2'd3, 32'h0);
      wr_coef(2'd0, 32'h0001_0000);   // address 0 must not touch h1
      clr();
      send(32'h0001_0000, 32'h0001_0000, 1);
      send(32'h0, 32'h0000_8000, 1);
      send(32'h0, 32'h0000_4000, 1);
      send(32'h0, 32'h0000_2000, 1);
      while (obs_q.size() - rd < 4 && t < 100) begin @(negedge i_clk); t++; end
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (rd >= obs_q.size()) begin n_err++; $display("FAIL impulse_missing[%0d]: none want %08h", i, exp_q[0]); end
         else begin
            if (obs_q[rd] !== exp_q[0]) begin n_err++; $display("FAIL impulse[%0d]: got %08h want %08h", i, obs_q[rd], exp_q[0]); end
            if (i > 0) begin
               n_vec++;
               if (obs_cyc[rd] - obs_cyc[rd-1] != 3) begin
                  n_err++; $display("FAIL impulse_spacing[%0d]: got %0d want 3", i, obs_cyc[rd] - obs_cyc[rd-1]);
               end
            end
            rd++;
         end
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_three_tap();
      int t = 0;
      wr_coef(2'd1, 32'h0001_0000); wr_coef(2'd2, 32'h0001_0000); wr_coef(2'd3, 32'h0001_0000);
      clr();
      send(32'h0001_0000, 32'h0001_0000, 1);
      send(32'h0, 32'h0001_0000, 1);
      send(32'h0, 32'h0002_0000, 1);
      send(32'h0, 32'h0004_0000, 1);
      while (obs_q.size() - rd < 4 && t < 100) begin @(negedge i_clk); t++; end
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (rd >= obs_q.size()) begin n_err++; $display("FAIL three_tap_missing[%0d]: none want %08h", i, exp_q[0]); end
         else begin
            if (obs_q[rd] !== exp_q[0]) begin n_err++; $display("FAIL three_tap[%0d]: got %08h want %08h", i, obs_q[rd], exp_q[0]); end
            rd++;
         end
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_saturation();
      int t = 0;
      wr_coef(2'd1, 32'h0001_0000); wr_coef(2'd2, 32'h0); wr_coef(2'd3, 32'h0);
      clr();
      send(32'h4000_0000, 32'h4000_0000, 1);
      send(32'h4000_0000, 32'h7FFF_FFFF, 1);
      send(32'h0,         32'h7FFF_FFFF, 1);
      // Huge product saturates before the add: 0x7FFFFFFF + 0x80000000 = -1
      wr_coef(2'd1, 32'h7FFF_FFFF);
      send(32'h8000_0000, 32'hFFFF_FFFF, 1);
      wr_coef(2'd1, 32'h0001_0000);
      clr();
      send(32'hC000_0000, 32'hC000_0000, 1);
      send(32'hC000_0000, 32'h8000_0000, 1);
      while (obs_q.size() - rd < 6 && t < 200) begin @(negedge i_clk); t++; end
      for (int i = 0; i < 6; i++) begin
         n_vec++;
         if (rd >= obs_q.size()) begin n_err++; $display("FAIL saturation_missing[%0d]: none want %08h", i, exp_q[0]); end
         else begin
            if (obs_q[rd] !== exp_q[0]) begin n_err++; $display("FAIL saturation[%0d]: got %08h want %08h", i, obs_q[rd], exp_q[0]); end
            rd++;
         end
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_floor();
      int t = 0;
      wr_coef(2'd1, 32'h0000_8000); wr_coef(2'd2, 32'h0); wr_coef(2'd3, 32'h0);
      clr();
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
      send(32'h0,         32'hFFFF_FFFF, 1);
      while (obs_q.size() - rd < 2 && t < 100) begin @(negedge i_clk); t++; end
      for (int i = 0; i < 2; i++) begin
         n_vec++;
         if (rd >= obs_q.size()) begin n_err++; $display("FAIL floor_missing[%0d]: none want %08h", i, exp_q[0]); end
         else begin
            if (obs_q[rd] !== exp_q[0]) begin n_err++; $display("FAIL floor[%0d]: got %08h want %08h", i, obs_q[rd], exp_q[0]); end
            rd++;
         end
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_back_to_back();
      int t = 0;
      int acc_cnt = 0;
      wr_coef(2'd1, 32'h0); wr_coef(2'd2, 32'h0); wr_coef(2'd3, 32'h0);
      clr();
      i_valid = 1'b1; i_e = 32'h0000_1234;
      for (int i = 0; i < 12; i++) begin
         n_vec++;
         if (o_ready !== ((i % 3) == 0)) begin
            n_err++; $display("FAIL b2b_ready[%0d]: got %0b want %0b", i, o_ready, (i % 3) == 0);
         end
         if (o_ready) begin acc_cnt++; exp_q.push_back(32'h0000_1234); end
         @(negedge i_clk);
      end
      i_valid = 1'b0;
      n_vec++; if (acc_cnt != 4) begin n_err++; $display("FAIL b2b_accepts: got %0d want 4", acc_cnt); end
      while (obs_q.size() - rd < 4 && t < 100) begin @(negedge i_clk); t++; end
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (rd >= obs_q.size()) begin n_err++; $display("FAIL b2b_missing[%0d]: none want 00001234", i); end
         else begin
            if (obs_q[rd] !== exp_q[0]) begin n_err++; $display("FAIL b2b[%0d]: got %08h want %08h", i, obs_q[rd], exp_q[0]); end
            rd++;
         end
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
   endtask

   task automatic test_clear_mid();
      int t = 0;
      wr_coef(2'd1, 32'h0001_0000); wr_coef(2'd2, 32'h0); wr_coef(2'd3, 32'h0);
      clr();
      send(32'h0001_0000, 32'h0001_0000, 1);
      send(32'h0002_0000, 32'h0003_0000, 1);  // returns with DUT in MUL
      clr();                                  // deferred: this output still uses history
      send(32'h0001_0000, 32'h0001_0000, 1);  // history zeroed -> no feedback
      while (obs_q.size() - rd < 3 && t < 100) begin @(negedge i_clk); t++; end
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (rd >= obs_q.size()) begin n_err++; $display("FAIL clear_mid_missing[%0d]: none want %08h", i, exp_q[0]); end
         else begin
            if (obs_q[rd] !== exp_q[0]) begin n_err++; $display("FAIL clear_mid[%0d]: got %08h want %08h", i, obs_q[rd], exp_q[0]); end
            rd++;
         end
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_coef_mid();
      int t = 0;
      wr_coef(2'd1, 32'h0000_8000); wr_coef(2'd2, 32'h0); wr_coef(2'd3, 32'h0);
      clr();
      send(32'h0001_0000, 32'h0001_0000, 1);
      send(32'h0, 32'h0000_8000, 1);           // returns in MUL
      wr_coef(2'd1, 32'h0001_0000);            // lands with MUL: this sample keeps 0.5
      send(32'h0, 32'h0000_8000, 1);           // 1.0 * 0.5 -> 0.5
      while (obs_q.size() - rd < 3 && t < 100) begin @(negedge i_clk); t++; end
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (rd >= obs_q.size()) begin n_err++; $display("FAIL coef_mid_missing[%0d]: none want %08h", i, exp_q[0]); end
         else begin
            if (obs_q[rd] !== exp_q[0]) begin n_err++; $display("FAIL coef_mid[%0d]: got %08h want %08h", i, obs_q[rd], exp_q[0]); end
            rd++;
         end
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_reset_mid();
      int t = 0;
      send(32'h0001_0000, 32'h0, 0);   // returns in MUL
      @(negedge i_clk);                // now in ACC
      i_rst_n = 1'b0; i_clear = 1'b1;
      @(negedge i_clk);
      i_clear = 1'b0;
      n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %0b want 0", o_valid); end
      n_vec++; if (o_d !== 32'h0) begin n_err++; $display("FAIL rst_mid_d: got %08h want 00000000", o_d); end
      i_rst_n = 1'b1;
      @(negedge i_clk);
      n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %0b want 1", o_ready); end
      n_vec++; if (obs_q.size() != rd) begin n_err++; $display("FAIL rst_mid_spurious: got %0d outputs want 0", obs_q.size() - rd); end
      rd = obs_q.size();
      // Coefficients and history were cleared, so the output is e itself
      send(32'h0000_5000, 32'h0000_5000, 1);
      while (obs_q.size() - rd < 1 && t < 100) begin @(negedge i_clk); t++; end
      n_vec++;
      if (rd >= obs_q.size()) begin n_err++; $display("FAIL rst_mid_after_missing: none want 00005000"); end
      else begin
         if (obs_q[rd] !== exp_q[0]) begin n_err++; $display("FAIL rst_mid_after: got %08h want %08h", obs_q[rd], exp_q[0]); end
         rd++;
      end
      void'(exp_q.pop_front());
   endtask

   initial begin
      @(negedge i_clk);
      test_reset();
      test_impulse();
      test_three_tap();
      test_saturation();
      test_floor();
      test_back_to_back();
      test_clear_mid();
      test_coef_mid();
      test_reset_mid();
      repeat (5) @(negedge i_clk);
      n_vec++;
      if (obs_q.size() != rd) begin n_err++; $display("FAIL extra_outputs: got %0d want 0", obs_q.size() - rd); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
